// File: rtl/alu_core.sv
// alu_core: ALU behind a valid/ready request stream. It produces a registered
// result together with a one-cycle done pulse.
// add/and/xor take one cycle in EXEC. mul is a shift-add over OP_WIDTH cycles
// in MUL.
// Build option: define ALU_CORE_MUL_EN to include the multiplier. Without it,
// op 100 is handled as a reserved opcode.
// Ports:
//   clk        clock, rising edge
//   alu_rst    asynchronous active-low reset
//   valid      request strobe, only looked at while ready=1
//   op, a, b   opcode and operands, captured on accept
//   ready      unit idle and able to accept a request
//   done       one-cycle pulse when result is updated
//   result     result of the last completed op (2*OP_WIDTH bits)
//   result_op  opcode that produced result
module alu_core #(
    parameter int unsigned OP_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    alu_rst,
    input  logic                    valid,
    input  logic [2:0]              op,
    input  logic [OP_WIDTH-1:0]     a,
    input  logic [OP_WIDTH-1:0]     b,
    output logic                    ready,
    output logic                    done,
    output logic [2*OP_WIDTH-1:0]   result,
    output logic [2:0]              result_op
);

    localparam int unsigned RW = 2 * OP_WIDTH;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
`ifdef ALU_CORE_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam int unsigned CW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
`endif

    typedef enum logic [2:0] {
        RESET_WAIT,
        IDLE,
        EXEC,
        MUL,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic [RW-1:0]          result_q, result_d;
    logic [2:0]             result_op_q, result_op_d;
    logic [2:0]             op_q, op_d;
    logic [OP_WIDTH-1:0]    a_q, a_d;
    logic [OP_WIDTH-1:0]    b_q, b_d;
`ifdef ALU_CORE_MUL_EN
    logic [RW-1:0]          acc_q, acc_d;
    logic [RW-1:0]          mcand_q, mcand_d;
    logic [OP_WIDTH-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          acc_step;
`endif
    logic                   accept;

    assign ready     = ready_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_op = result_op_q;

    // ready is registered, so a request seen with ready=1 is a real handshake.
    assign accept = valid && ready_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge alu_rst) begin
        if (!alu_rst) begin
            state_q     <= RESET_WAIT;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_op_q <= 3'b000;
            op_q        <= 3'b000;
            a_q         <= '0;
            b_q         <= '0;
`ifdef ALU_CORE_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_op_q <= result_op_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
`ifdef ALU_CORE_MUL_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        result_d    = result_q;
        result_op_d = result_op_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
`ifdef ALU_CORE_MUL_EN
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        // Add the shifted multiplicand when the current multiplier bit is set.
        acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

        case (state_q)
            RESET_WAIT: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end

            // DONE accepts a request exactly like IDLE, which allows back-to-back requests.
            IDLE, DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
                if (accept) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    ready_d = 1'b0;
                    case (op)
                        OP_ADD, OP_AND, OP_XOR: state_d = EXEC;
`ifdef ALU_CORE_MUL_EN
                        OP_MUL: begin
                            state_d  = MUL;
                            acc_d    = '0;
                            mcand_d  = RW'(a);
                            mplier_d = b;
                            cnt_d    = '0;
                        end
`endif
                        // no_op, reserved and rst_op only produce the one-cycle ready drop.
                        default: state_d = IDLE;
                    endcase
                end
            end

            EXEC: begin
                case (op_q)
                    OP_ADD:  result_d = RW'({1'b0, a_q} + {1'b0, b_q});
                    OP_AND:  result_d = RW'(a_q & b_q);
                    OP_XOR:  result_d = RW'(a_q ^ b_q);
                    default: result_d = '0;
                endcase
                result_op_d = op_q;
                done_d      = 1'b1;
                ready_d     = 1'b1;
                state_d     = DONE;
            end

`ifdef ALU_CORE_MUL_EN
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // The last step publishes the accumulator directly. This saves one cycle.
                if (cnt_q == CW'(OP_WIDTH - 1)) begin
                    result_d    = acc_step;
                    result_op_d = OP_MUL;
                    done_d      = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = DONE;
                end
            end
`endif

            default: state_d = RESET_WAIT;
        endcase
    end

endmodule
